pong_game_ctrl: RTL and testbench

- Per-frame game-state controller for Pong.
- Owns the paddle positions, ball position/direction, scores and match state machine.
- Feeds the image generator's paddle/ball geometry inputs.
- Advances once per frame on a single-cycle frame_tick from the VGA timing block, so geometry is stable while pixels are drawn.

---
 rtl/pong_game_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong per-frame game-state controller.
// Holds paddle positions, ball position/direction, scores and the match FSM.
// Every state change happens on reset, on an accepted start, or on a frame_tick
// cycle, so the geometry outputs stay constant while a frame is being drawn.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X1    = 16,
  parameter int PADDLE_X2    = 616,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_DELAY  = 60
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  output logic [11:0] top_player_1,
  output logic [11:0] top_player_2,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic [2:0]  game_state,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Geometry constants in the 12-bit datapath width.
  localparam logic [11:0] PAD_MAX    = 12'(SCREEN_H - PADDLE_H);
  localparam logic [11:0] PAD_CENTRE = 12'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [11:0] BALL_CX    = 12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_CY    = 12'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_X_MAX = 12'(SCREEN_W - BALL_SIZE);
  localparam logic [11:0] BALL_Y_MAX = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [11:0] LEFT_FACE  = 12'(PADDLE_X1 + PADDLE_W);
  localparam logic [11:0] RIGHT_FACE = 12'(PADDLE_X2);
  localparam logic [11:0] RIGHT_STOP = 12'(PADDLE_X2 - BALL_SIZE);
  localparam logic [11:0] PAD_H      = 12'(PADDLE_H);
  localparam logic [11:0] BSZ        = 12'(BALL_SIZE);
  localparam logic [11:0] PSPD       = 12'(PADDLE_SPEED);
  localparam logic [11:0] BSPD       = 12'(BALL_SPEED);
  localparam logic [3:0]  WIN_PTS    = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LAST = 16'(SERVE_DELAY - 1);

  state_t      state_reg, state_next;
  logic [11:0] top1_reg, top1_next;
  logic [11:0] top2_reg, top2_next;
  logic [11:0] ball_x_reg, ball_x_next;
  logic [11:0] ball_y_reg, ball_y_next;
  logic        dx_reg, dx_next;          // 1 = moving right (+x)
  logic        dy_reg, dy_next;          // 1 = moving down  (+y)
  logic [3:0]  score1_reg, score1_next;
  logic [3:0]  score2_reg, score2_next;
  logic [1:0]  winner_reg, winner_next;
  logic [15:0] serve_cnt_reg, serve_cnt_next;

  logic        start_accept;
  logic        overlap_1, overlap_2;
  logic        hit_left, hit_right;
  logic        miss_left, miss_right;
  logic [3:0]  score1_inc, score2_inc;

  // One paddle step with clamping; bounds are checked before any add/subtract
  // so the position never wraps.
  function automatic logic [11:0] paddle_step(input logic [11:0] pos,
                                              input logic up,
                                              input logic down);
    logic [11:0] res;
    res = pos;
    if (up && !down) begin
      if (pos < PSPD) res = 12'd0;
      else            res = pos - PSPD;
    end else if (down && !up) begin
      if (pos > PAD_MAX - PSPD) res = PAD_MAX;
      else                      res = pos + PSPD;
    end
    return res;
  endfunction

  // Collision and miss detection from the pre-tick ball and paddle positions.
  always_comb begin
    start_accept = start && ((state_reg == IDLE) || (state_reg == OVER));
    overlap_1    = (ball_y_reg + BSZ > top1_reg) && (ball_y_reg < top1_reg + PAD_H);
    overlap_2    = (ball_y_reg + BSZ > top2_reg) && (ball_y_reg < top2_reg + PAD_H);
    hit_left     = !dx_reg && (ball_x_reg >= LEFT_FACE) &&
                   (ball_x_reg <= LEFT_FACE + BSPD) && overlap_1;
    hit_right    = dx_reg && (ball_x_reg + BSZ <= RIGHT_FACE) &&
                   (ball_x_reg + BSZ + BSPD >= RIGHT_FACE) && overlap_2;
    miss_left    = !dx_reg && (ball_x_reg < BSPD);
    miss_right   = dx_reg && (ball_x_reg + BSPD > BALL_X_MAX);
    score1_inc   = score1_reg + 4'd1;
    score2_inc   = score2_reg + 4'd1;
  end

  // Next-state logic: match FSM, paddle movement and ball physics.
  always_comb begin
    state_next     = state_reg;
    top1_next      = top1_reg;
    top2_next      = top2_reg;
    ball_x_next    = ball_x_reg;
    ball_y_next    = ball_y_reg;
    dx_next        = dx_reg;
    dy_next        = dy_reg;
    score1_next    = score1_reg;
    score2_next    = score2_reg;
    winner_next    = winner_reg;
    serve_cnt_next = serve_cnt_reg;

    if (start_accept) begin
      // Start wins over the frame update for this cycle.
      if (state_reg == OVER) begin
        score1_next = 4'd0;
        score2_next = 4'd0;
        winner_next = 2'd0;
        top1_next   = PAD_CENTRE;
        top2_next   = PAD_CENTRE;
      end
      ball_x_next    = BALL_CX;
      ball_y_next    = BALL_CY;
      serve_cnt_next = 16'd0;
      state_next     = SERVE;
    end else if (frame_tick && (state_reg != OVER)) begin
      top1_next = paddle_step(top1_reg, p1_up, p1_down);
      top2_next = paddle_step(top2_reg, p2_up, p2_down);

      case (state_reg)
        SERVE: begin
          serve_cnt_next = serve_cnt_reg + 16'd1;
          if (serve_cnt_reg == SERVE_LAST) state_next = PLAY;
        end

        PLAY: begin
          // Vertical bounce off the top and bottom walls.
          if (!dy_reg && (ball_y_reg < BSPD)) begin
            ball_y_next = 12'd0;
            dy_next     = 1'b1;
          end else if (dy_reg && (ball_y_reg + BSPD > BALL_Y_MAX)) begin
            ball_y_next = BALL_Y_MAX;
            dy_next     = 1'b0;
          end else if (dy_reg) begin
            ball_y_next = ball_y_reg + BSPD;
          end else begin
            ball_y_next = ball_y_reg - BSPD;
          end

          // Horizontal: paddle returns take priority over a miss. On a miss
          // the ball and dx are left as-is; dx then identifies the scorer.
          if (hit_left) begin
            ball_x_next = LEFT_FACE;
            dx_next     = 1'b1;
          end else if (hit_right) begin
            ball_x_next = RIGHT_STOP;
            dx_next     = 1'b0;
          end else if (miss_left || miss_right) begin
            state_next = POINT;
          end else if (dx_reg) begin
            ball_x_next = ball_x_reg + BSPD;
          end else begin
            ball_x_next = ball_x_reg - BSPD;
          end
        end

        POINT: begin
          ball_x_next    = BALL_CX;
          ball_y_next    = BALL_CY;
          serve_cnt_next = 16'd0;
          state_next     = SERVE;
          if (dx_reg) begin
            // Ball left through the right edge: player 1 scores, serve toward P2.
            score1_next = score1_inc;
            dx_next     = 1'b1;
            if (score1_inc == WIN_PTS) begin
              winner_next = 2'd1;
              state_next  = OVER;
            end
          end else begin
            score2_next = score2_inc;
            dx_next     = 1'b0;
            if (score2_inc == WIN_PTS) begin
              winner_next = 2'd2;
              state_next  = OVER;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // State register with synchronous reset to the centred starting position.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_reg     <= IDLE;
      top1_reg      <= PAD_CENTRE;
      top2_reg      <= PAD_CENTRE;
      ball_x_reg    <= BALL_CX;
      ball_y_reg    <= BALL_CY;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      score1_reg    <= 4'd0;
      score2_reg    <= 4'd0;
      winner_reg    <= 2'd0;
      serve_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      top1_reg      <= top1_next;
      top2_reg      <= top2_next;
      ball_x_reg    <= ball_x_next;
      ball_y_reg    <= ball_y_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      score1_reg    <= score1_next;
      score2_reg    <= score2_next;
      winner_reg    <= winner_next;
      serve_cnt_reg <= serve_cnt_next;
    end
  end

  assign top_player_1 = top1_reg;
  assign top_player_2 = top2_reg;
  assign ball_x       = ball_x_reg;
  assign ball_y       = ball_y_reg;
  assign score_1      = score1_reg;
  assign score_2      = score2_reg;
  assign game_state   = state_reg;
  assign winner       = winner_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: a frame-level game model checked every cycle,
// plus hand-computed expectations along a directed match script.
module tb_pong_game_ctrl;

  logic        CLOCK_25 = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [11:0] top_player_1, top_player_2, ball_x, ball_y;
  logic [3:0]  score_1, score_2;
  logic [2:0]  game_state;
  logic [1:0]  winner;

  pong_game_ctrl dut (
    .CLOCK_25    (CLOCK_25),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .p1_up       (p1_up),
    .p1_down     (p1_down),
    .p2_up       (p2_up),
    .p2_down     (p2_down),
    .top_player_1(top_player_1),
    .top_player_2(top_player_2),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .score_1     (score_1),
    .score_2     (score_2),
    .game_state  (game_state),
    .winner      (winner)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    logic [31:0] e;
    e = exp;
    n_vec++;
    if (act !== e) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model (screen coordinates as ints) ----
  int m_t1, m_t2, m_bx, m_by, m_vx, m_vy, m_s1, m_s2, m_st, m_win, m_ticks, m_scorer;
  bit m_valid = 1'b0;

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic bit overlaps(input int by, input int top);
    return (by + 8 > top) && (by < top + 64);
  endfunction

  task automatic model_step();
    int o1, o2, ny, nx;
    bit hl, hr;
    if (reset) begin
      m_t1 = 208; m_t2 = 208; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
      m_s1 = 0; m_s2 = 0; m_st = 0; m_win = 0; m_ticks = 0; m_scorer = 0;
      m_valid = 1'b1;
    end else if (start && (m_st == 0 || m_st == 4)) begin
      if (m_st == 4) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_t1 = 208; m_t2 = 208;
      end
      m_bx = 316; m_by = 236; m_st = 1; m_ticks = 0;
    end else if (frame_tick && m_st != 4) begin
      o1 = m_t1; o2 = m_t2;
      m_t1 = clampi(m_t1 + 4 * (int'(p1_down) - int'(p1_up)), 0, 416);
      m_t2 = clampi(m_t2 + 4 * (int'(p2_down) - int'(p2_up)), 0, 416);
      case (m_st)
        1: begin
          m_ticks++;
          if (m_ticks == 60) m_st = 2;
        end
        2: begin
          ny = m_by + m_vy;
          if (ny < 0)        begin ny = 0;   m_vy = 2;  end
          else if (ny > 472) begin ny = 472; m_vy = -2; end
          hl = (m_vx < 0) && (m_bx >= 24) && (m_bx - 2 <= 24) && overlaps(m_by, o1);
          hr = (m_vx > 0) && (m_bx + 8 <= 616) && (m_bx + 10 >= 616) && overlaps(m_by, o2);
          nx = m_bx + m_vx;
          if (hl)            begin nx = 24;  m_vx = 2;  end
          else if (hr)       begin nx = 608; m_vx = -2; end
          else if (nx < 0)   begin nx = m_bx; m_scorer = 2; m_st = 3; end
          else if (nx > 632) begin nx = m_bx; m_scorer = 1; m_st = 3; end
          m_bx = nx; m_by = ny;
        end
        3: begin
          m_bx = 316; m_by = 236; m_ticks = 0; m_st = 1;
          if (m_scorer == 1) begin
            m_s1++; m_vx = 2;
            if (m_s1 == 7) begin m_win = 1; m_st = 4; end
          end else begin
            m_s2++; m_vx = -2;
            if (m_s2 == 7) begin m_win = 2; m_st = 4; end
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge CLOCK_25) model_step();

  // Per-cycle comparison of every output against the model.
  always @(negedge CLOCK_25) begin
    if (m_valid) begin
      chk("top_player_1", top_player_1, m_t1);
      chk("top_player_2", top_player_2, m_t2);
      chk("ball_x", ball_x, m_bx);
      chk("ball_y", ball_y, m_by);
      chk("score_1", score_1, m_s1);
      chk("score_2", score_2, m_s2);
      chk("game_state", game_state, m_st);
      chk("winner", winner, m_win);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_top1"}, top_player_1, 208);
    chk({tag, "_top2"}, top_player_2, 208);
    chk({tag, "_bx"}, ball_x, 316);
    chk({tag, "_by"}, ball_y, 236);
    chk({tag, "_s1"}, score_1, 0);
    chk({tag, "_s2"}, score_2, 0);
    chk({tag, "_state"}, game_state, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask

  initial begin
    int guard;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    $display("step: reset");
    chk_reset_values("rst");

    $display("step: p1_up x10");
    p1_up = 1'b1; tick_n(10); p1_up = 1'b0;
    chk("p1_up10_top1", top_player_1, 168);
    chk("p1_up10_state", game_state, 0);
    chk("p1_up10_bx", ball_x, 316);
    chk("p1_up10_by", ball_y, 236);

    $display("step: p2_down x200");
    p2_down = 1'b1; tick_n(200); p2_down = 1'b0;
    chk("p2_sat_top2", top_player_2, 416);

    $display("step: p1 both buttons x5");
    p1_up = 1'b1; p1_down = 1'b1; tick_n(5); p1_up = 1'b0; p1_down = 1'b0;
    chk("p1_both_top1", top_player_1, 168);

    $display("step: p1_up x50 to top");
    p1_up = 1'b1; tick_n(50); p1_up = 1'b0;
    chk("p1_floor_top1", top_player_1, 0);

    $display("step: p2_up x104 to top");
    p2_up = 1'b1; tick_n(104); p2_up = 1'b0;
    chk("p2_park_top2", top_player_2, 0);

    $display("step: start with frame_tick in IDLE");
    p1_down = 1'b1; start = 1'b1; frame_tick = 1'b1;
    cyc();
    p1_down = 1'b0; start = 1'b0; frame_tick = 1'b0;
    cyc();
    chk("start_tick_top1", top_player_1, 0);
    chk("start_tick_state", game_state, 1);

    $display("step: serve 60 ticks");
    tick_n(59);
    chk("serve59_state", game_state, 1);
    tick_n(1);
    chk("serve60_state", game_state, 2);
    chk("serve60_bx", ball_x, 316);
    chk("serve60_by", ball_y, 236);
    tick_n(1);
    chk("play1_bx", ball_x, 318);
    chk("play1_by", ball_y, 238);

    $display("step: bottom wall bounce");
    tick_n(117);
    chk("play118_by", ball_y, 472);
    tick_n(1);
    chk("play119_by", ball_y, 472);
    tick_n(1);
    chk("play120_by", ball_y, 470);

    $display("step: P2 misses");
    tick_n(38);
    chk("play158_state", game_state, 2);
    chk("play158_bx", ball_x, 632);
    tick_n(1);
    chk("miss_state", game_state, 3);
    tick_n(1);
    chk("point_state", game_state, 1);
    chk("point_s1", score_1, 1);
    chk("point_s2", score_2, 0);
    chk("point_bx", ball_x, 316);
    chk("point_by", ball_y, 236);

    $display("step: park p2 mid-screen, play to 7");
    p2_down = 1'b1; tick_n(52); p2_down = 1'b0;
    chk("p2_mid_top2", top_player_2, 208);
    guard = 0;
    while (m_st != 4 && guard < 3000) begin
      tick_n(1);
      guard++;
    end
    chk("over_reached", game_state, 4);
    chk("over_s1", score_1, 7);
    chk("over_s2", score_2, 0);
    chk("over_winner", winner, 1);

    $display("step: OVER ignores buttons and ticks");
    p1_down = 1'b1; p2_up = 1'b1; tick_n(20); p1_down = 1'b0; p2_up = 1'b0;
    chk("frozen_state", game_state, 4);
    chk("frozen_top1", top_player_1, 0);
    chk("frozen_top2", top_player_2, 208);
    chk("frozen_s1", score_1, 7);

    $display("step: restart from OVER");
    start = 1'b1; cyc(); start = 1'b0; cyc();
    chk("restart_state", game_state, 1);
    chk("restart_s1", score_1, 0);
    chk("restart_winner", winner, 0);
    chk("restart_top1", top_player_1, 208);
    chk("restart_top2", top_player_2, 208);
    chk("restart_bx", ball_x, 316);

    $display("step: serve while positioning paddles");
    for (int i = 0; i < 60; i++) begin
      p1_down = (i < 12);
      p2_up   = (i < 52);
      tick_n(1);
    end
    p1_down = 1'b0; p2_up = 1'b0;
    chk("rally_state", game_state, 2);
    chk("rally_top1", top_player_1, 256);
    chk("rally_top2", top_player_2, 0);

    $display("step: right paddle return");
    tick_n(145);
    chk("pre_right_bx", ball_x, 606);
    chk("pre_right_by", ball_y, 52);
    tick_n(1);
    chk("right_hit_bx", ball_x, 608);
    chk("right_hit_by", ball_y, 54);

    $display("step: left paddle return");
    tick_n(291);
    chk("pre_left_bx", ball_x, 26);
    chk("pre_left_by", ball_y, 310);
    tick_n(1);
    chk("left_hit_bx", ball_x, 24);
    chk("left_hit_state", game_state, 2);
    tick_n(1);
    chk("left_after_bx", ball_x, 26);
    chk("left_after_s2", score_2, 0);

    $display("step: reset mid-PLAY");
    tick_n(5);
    reset = 1'b1; cyc();
    chk_reset_values("midrst");
    reset = 1'b0; cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
